// File: rtl/fetch_unit.sv
// fetch_unit: program counter plus single-outstanding instruction fetch.
// Issues one read at a time over a valid/ready handshake, presents each
// returned word with its PC to decode, and squashes in-flight work on redirect.
// Optional build macro FETCH_PERF_EN adds fetch/wait performance counters.
module fetch_unit #(
    parameter int unsigned                ADDR_WIDTH  = 32,
    parameter int unsigned                INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]      PC_STEP     = 1,
    parameter logic [ADDR_WIDTH-1:0]      RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   mem_req_valid,
    output logic [ADDR_WIDTH-1:0]  mem_req_addr,
    input  logic                   mem_req_ready,
    input  logic                   mem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] mem_rsp_data,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    input  logic                   instr_ready,
    output logic [ADDR_WIDTH-1:0]  pc_value
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            perf_fetch_count,
    output logic [31:0]            perf_wait_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  req_pc_q, req_pc_d;
    logic                   discard_q, discard_d;
    logic [INSTR_WIDTH-1:0] instr_data_q, instr_data_d;
    logic [ADDR_WIDTH-1:0]  instr_pc_q, instr_pc_d;

    // State register; reset is asynchronous so outputs drop the moment rst falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            discard_q    <= 1'b0;
            instr_data_q <= '0;
            instr_pc_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            discard_q    <= discard_d;
            instr_data_q <= instr_data_d;
            instr_pc_q   <= instr_pc_d;
        end
    end

    // Next-state logic: request, wait for data, hold until decode takes it.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        discard_d    = discard_q;
        instr_data_d = instr_data_q;
        instr_pc_d   = instr_pc_q;

        case (state_q)
            ST_REQ: begin
                if (mem_req_ready) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + PC_STEP;
                    state_d  = ST_WAIT;
                    // Request already went out, so its answer must be thrown away.
                    if (redirect_valid) discard_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    if (discard_q || redirect_valid) begin
                        discard_d = 1'b0;
                        state_d   = ST_REQ;
                    end else begin
                        instr_data_d = mem_rsp_data;
                        instr_pc_d   = req_pc_q;
                        state_d      = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    discard_d = 1'b1;
                end
            end
            ST_HOLD: begin
                // A redirect kills the held word; if decode took it this cycle it still counts.
                if (instr_ready || redirect_valid) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
        endcase

        // Redirect beats the normal increment in every state.
        if (redirect_valid) pc_d = redirect_pc;
    end

    assign mem_req_valid = rst && (state_q == ST_REQ);
    assign mem_req_addr  = pc_q;
    assign instr_valid   = (state_q == ST_HOLD);
    assign instr_data    = instr_data_q;
    assign instr_pc      = instr_pc_q;
    assign pc_value      = pc_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, wait_cnt_q;

    // Free-running wrap-around counters for delivered words and WAIT residency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            if (instr_valid && instr_ready) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (state_q == ST_WAIT)         wait_cnt_q  <= wait_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_count = fetch_cnt_q;
    assign perf_wait_cycles = wait_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: drives fetch_unit against a behavioural memory and a
// program-order model (expected PC stream, redirect retargeting).
// Build with FETCH_PERF_EN defined to also check the performance counters.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic [31:0] pc_value;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_instr_valid;
    logic [31:0] w_instr_data;
    logic [31:0] w_instr_pc;
    logic [31:0] w_pc;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_count, perf_wait_cycles;
    logic [31:0] w_perf_fetch, w_perf_wait;
    int          exp_fetch = 0;
    int          exp_wait  = 0;
`endif

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .pc_value(pc_value)
`ifdef FETCH_PERF_EN
        , .perf_fetch_count(perf_fetch_count), .perf_wait_cycles(perf_wait_cycles)
`endif
    );

    // Second instance near the top of the address space; timing is address independent,
    // so it sees the same handshakes as the main instance.
    fetch_unit #(.RESET_PC(32'hFFFF_FFFE)) dut_wrap (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(w_req_valid), .mem_req_addr(w_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .instr_valid(w_instr_valid), .instr_data(w_instr_data), .instr_pc(w_instr_pc),
        .instr_ready(instr_ready), .pc_value(w_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetch_count(w_perf_fetch), .perf_wait_cycles(w_perf_wait)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] exp_pc, next_req, pend_addr, held_data, held_pc, last_pc;
    bit          pend, held_prev, clear_prev, stale_fire, req_fired;
    int          cnt, lat_cfg, delivered, wrap_n, wrap_d;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc = 32'h0; next_req = 32'h0;
        pend = 0; held_prev = 0; clear_prev = 0; stale_fire = 0;
        wrap_n = 0; wrap_d = 0;
`ifdef FETCH_PERF_EN
        exp_fetch = 0; exp_wait = 0;
`endif
    endtask

    // One clock cycle: check what the last edge produced, drive this cycle's
    // inputs, then advance the model to what the coming edge must do.
    task automatic tick(input bit rrdy, input bit irdy, input bit redir, input logic [31:0] rpc);
        bit outstanding;
        @(negedge clk);
        if (clear_prev) chk("valid_drop", 32'(instr_valid), 32'd0);
        if (held_prev) begin
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_data", instr_data, held_data);
            chk("hold_pc", instr_pc, held_pc);
        end
        chk("single_outstanding", 32'(mem_req_valid && instr_valid), 32'd0);
        chk("twin_valid", 32'(w_instr_valid), 32'(instr_valid));
`ifdef FETCH_PERF_EN
        chk("perf_fetch", perf_fetch_count, 32'(exp_fetch));
        chk("perf_wait", perf_wait_cycles, 32'(exp_wait));
`endif
        mem_req_ready  = rrdy;
        instr_ready    = irdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = $urandom;
        outstanding    = pend;
        if (stale_fire) begin
            mem_rsp_valid = 1'b1;
            stale_fire    = 0;
        end else if (pend) begin
            if (cnt == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = memfn(pend_addr);
                pend          = 0;
            end else begin
                cnt--;
            end
        end else if ($urandom_range(0, 9) == 0) begin
            mem_rsp_valid = 1'b1;   // no read pending: must be ignored
        end
        #1;
        clear_prev = redir || (instr_valid && irdy);
        held_prev  = instr_valid && !irdy && !redir;
        held_data  = instr_data;
        held_pc    = instr_pc;
`ifdef FETCH_PERF_EN
        if (outstanding) exp_wait++;
        if (instr_valid && irdy) exp_fetch++;
`endif
        if (instr_valid && irdy) begin
            chk("instr_pc", instr_pc, exp_pc);
            chk("instr_data", instr_data, memfn(exp_pc));
            if (wrap_d < 3) begin
                chk("wrap_instr_pc", w_instr_pc, 32'hFFFF_FFFE + 32'(wrap_d));
                wrap_d++;
            end
            $display("deliver pc=%h data=%h", instr_pc, instr_data);
            last_pc = instr_pc;
            exp_pc  = exp_pc + 32'd1;
            delivered++;
        end
        if (mem_req_valid && rrdy) begin
            chk("req_addr", mem_req_addr, next_req);
            if (wrap_n < 3) begin
                chk("wrap_req_valid", 32'(w_req_valid), 32'd1);
                chk("wrap_req_addr", w_req_addr, 32'hFFFF_FFFE + 32'(wrap_n));
                wrap_n++;
            end
            pend      = 1;
            pend_addr = mem_req_addr;
            cnt       = (lat_cfg == 0) ? int'($urandom_range(0, 3)) : lat_cfg - 1;
            next_req  = next_req + 32'd1;
            req_fired = 1;
        end
        if (redir) begin
            exp_pc   = rpc;
            next_req = rpc;
        end
        @(posedge clk);
    endtask

    task automatic run_until_req();
        int n = 0;
        req_fired = 0;
        while (!req_fired && n < 20) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            n++;
        end
        chk("req_timeout", 32'(req_fired), 32'd1);
    endtask

    task automatic run_until_deliver();
        int n = 0;
        int d0 = delivered;
        while (delivered == d0 && n < 30) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            n++;
        end
        chk("deliver_timeout", 32'(delivered - d0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        model_reset();
        delivered = 0; lat_cfg = 1; last_pc = '0; req_fired = 0;

        // Power-on reset
        #2 rst = 1'b0;
        #1;
        chk("rst_pc", pc_value, 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_wrap_pc", w_pc, 32'hFFFF_FFFE);
        @(posedge clk); @(posedge clk);
        chk("rst_pc_held", pc_value, 32'h0);
        #3 rst = 1'b1;

        // Streaming at full rate: one word per three cycles, PCs 0,1,2,...
        for (int i = 0; i < 30; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("throughput", 32'(delivered), 32'd10);

        // Decode stalls while a word is held
        for (int i = 0; i < 9; i++) tick(1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect to 0x40 while waiting, response three cycles later
        lat_cfg = 4;
        run_until_req();
        tick(1'b0, 1'b1, 1'b1, 32'h40);
        lat_cfg = 1;
        run_until_deliver();
        chk("redir_wait_pc", last_pc, 32'h40);

        // Redirect to 0x80 together with request acceptance
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        run_until_deliver();
        tick(1'b1, 1'b1, 1'b1, 32'h80);
        run_until_deliver();
        chk("redir_req_pc", last_pc, 32'h80);

        // Random traffic: back-pressure, latency, redirects in every state
        lat_cfg = 0;
        for (int i = 0; i < 600; i++) begin
            bit rd = ($urandom_range(0, 19) == 0);
            tick($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, rd,
                 rd ? $urandom : 32'h0);
        end

        // Asynchronous reset in the middle of a wait
        lat_cfg = 3;
        run_until_req();
        #3;
        mem_req_ready = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; mem_rsp_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("async_instr_valid", 32'(instr_valid), 32'd0);
        chk("async_req_valid", 32'(mem_req_valid), 32'd0);
        chk("async_pc", pc_value, 32'h0);
`ifdef FETCH_PERF_EN
        chk("async_perf_fetch", perf_fetch_count, 32'd0);
        chk("async_perf_wait", perf_wait_cycles, 32'd0);
`endif
        model_reset();
        @(posedge clk); @(posedge clk);
        #3 rst = 1'b1;
        stale_fire = 1;
        lat_cfg = 1;
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        d0 = delivered;
        for (int i = 0; i < 30; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
        chk("restart_count", 32'(delivered - d0), 32'd10);
        chk("restart_last_pc", last_pc, 32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised program-counter and instruction-fetch block. It replaces the free-running PC-plus-one register in the CPU top. It holds the PC and issues one read request at a time to instruction memory over a valid/ready handshake. It presents each returned instruction with its PC to the decode stage, and accepts redirects (branch or jump) that squash in-flight work.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address
INSTR_WIDTH, 32, width of instruction word
PC_STEP, 1, increment added to PC per fetch (word-addressed memory: 1)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
redirect_valid  input  1  load redirect_pc into PC; highest priority
redirect_pc  input  ADDR_WIDTH  redirect target
mem_req_valid  output  1  read request valid
mem_req_addr  output  ADDR_WIDTH  read address (current PC)
mem_req_ready  input  1  memory accepts request
mem_rsp_valid  input  1  read data valid
mem_rsp_data  input  INSTR_WIDTH  read data
instr_valid  output  1  instruction available to decode
instr_data  output  INSTR_WIDTH  fetched instruction
instr_pc  output  ADDR_WIDTH  PC of instr_data
instr_ready  input  1  decode accepts instruction
pc_value  output  ADDR_WIDTH  debug: current PC register

Behaviour:
- Reset (rst=0, async)
  - pc=RESET_PC, state=REQ, discard=0.
  - instr_valid=0; instr_data, instr_pc and the internal req_pc=0.
  - mem_req_valid=0 while rst is low.
- Single outstanding request. States: REQ, WAIT, HOLD.
- REQ
  - mem_req_valid=1; mem_req_addr=pc (driven from the register, no combinational path from inputs).
  - On mem_req_ready: req_pc<=pc; pc<=pc+PC_STEP, truncated to ADDR_WIDTH (wraps at 2^ADDR_WIDTH); go WAIT.
- WAIT
  - mem_req_valid=0.
  - On mem_rsp_valid with discard=0: instr_data<=mem_rsp_data; instr_pc<=req_pc; go HOLD. instr_valid rises the following cycle (registered).
  - On mem_rsp_valid with discard=1: drop the data, clear discard, go REQ.
- HOLD
  - instr_valid=1; outputs remain stable until the handshake completes.
  - On instr_ready: go REQ, and instr_valid falls next cycle.
  - Throughput: one instruction per 3 cycles minimum with single-cycle memory.
- mem_rsp_valid in REQ or HOLD is ignored.
- Redirect (redirect_valid=1) overrides normal PC update: pc<=redirect_pc.
  - In REQ without mem_req_ready: stay REQ. The next cycle requests redirect_pc.
  - In REQ with mem_req_ready the same cycle: the request was consumed, so go WAIT with discard=1. The pc increment is suppressed.
  - In WAIT: discard<=1. If mem_rsp_valid arrives the same cycle, drop it and go REQ directly (discard stays 0).
  - In HOLD: instr_valid<=0, go REQ. If instr_ready was high the same cycle, the handshake counts as completed (consumer saw valid&ready).
  - Back-to-back redirects: the last one wins.
- pc_value = pc register at all times.

Optional Feature:
FETCH_PERF_EN
- Defined: adds output ports perf_fetch_count (32) and perf_wait_cycles (32). Both reset to 0.
  - perf_fetch_count increments on each instr_valid&instr_ready handshake.
  - perf_wait_cycles increments every cycle spent in WAIT.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, memory always ready, 1-cycle response, instr_ready=1 -> instr_pc sequence 0,1,2,3 with instr_data equal to memory contents; pc_value=0 during reset.
- RESET_PC=0xFFFFFFFE, PC_STEP=1 -> requests to 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 (wrap).
- Hold instr_ready=0 for 5 cycles in HOLD -> instr_valid/instr_data/instr_pc stable; no new mem_req_valid until the handshake.
- Redirect to 0x40 while in WAIT, response arrives 3 cycles later -> response dropped, no instr_valid for it, next mem_req_addr=0x40, next instr_pc=0x40.
- Redirect to 0x80 in the same cycle as mem_req_ready in REQ -> that response discarded; following request at 0x80.
- Assert rst low mid-WAIT (asynchronous, off clock edge) -> instr_valid and mem_req_valid go 0 immediately; after release fetch restarts at RESET_PC; the stale response is ignored. With FETCH_PERF_EN, both counters read 0.
